// File: rtl/decode_strobe.sv
// decode_strobe: a 3-to-8 style decoder that turns a single request into a
// timed, registered, active-low strobe on one output. Each strobe is followed
// by an all-high recovery gap. A one-entry buffer holds a request that arrives
// while a strobe is in progress.
module decode_strobe #(
  parameter int SEL_WIDTH    = 3,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        g1,
  input  logic                        g2a_n,
  input  logic                        g2b_n,
  input  logic [SEL_WIDTH-1:0]        a,
  input  logic                        req,
  output logic [(2**SEL_WIDTH)-1:0]   y_n,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun
);

  localparam int N = 2**SEL_WIDTH;
  localparam logic [3:0] PULSE_CNT = 4'(PULSE_CYCLES);
  localparam logic [3:0] GAP_CNT   = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic                 pend_vld;
  logic [SEL_WIDTH-1:0] pend_a;
  logic                 en;
  logic                 pend_take;

  // One-cold pattern: only the selected bit low.
  function automatic logic [N-1:0] onecold(input logic [SEL_WIDTH-1:0] sel);
    onecold = ~(N'(1) << sel);
  endfunction

  assign en   = g1 & ~g2a_n & ~g2b_n;
  assign busy = (state != IDLE);

  // Decide when the pending buffer captures the select input.
  always_comb begin
    pend_take = 1'b0;
    case (state)
      // In IDLE the buffer is freed by a launch, so a new request can refill it.
      IDLE:       pend_take = req & pend_vld & en;
      PULSE, GAP: pend_take = req & ~pend_vld;
      default:    pend_take = 1'b0;
    endcase
  end

  // Pending select value; pure data, qualified by pend_vld.
  always_ff @(posedge clk) begin
    if (pend_take) pend_a <= a;
  end

  // Strobe sequencer: state, cycle counter, outputs and pending/overrun flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      y_n      <= '1;
      done     <= 1'b0;
      overrun  <= 1'b0;
      pend_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          y_n <= '1;
          if (pend_vld) begin
            // Buffered request has priority; enables are re-checked now.
            if (en) begin
              state    <= PULSE;
              cnt      <= 4'd1;
              y_n      <= onecold(pend_a);
              pend_vld <= req;
            end else begin
              pend_vld <= 1'b0;
            end
          end else if (req && en) begin
            state <= PULSE;
            cnt   <= 4'd1;
            y_n   <= onecold(a);
          end
        end
        PULSE: begin
          if (req) begin
            if (pend_vld) overrun  <= 1'b1;
            else          pend_vld <= 1'b1;
          end
          // Either the full length elapsed or the enables dropped (abort).
          if (!en || cnt >= PULSE_CNT) begin
            y_n  <= '1;
            done <= en;
            if (GAP_CNT == 4'd0) begin
              state <= IDLE;
            end else begin
              state <= GAP;
              cnt   <= 4'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          if (req) begin
            if (pend_vld) overrun  <= 1'b1;
            else          pend_vld <= 1'b1;
          end
          y_n <= '1;
          if (cnt >= GAP_CNT) state <= IDLE;
          else                cnt   <= cnt + 4'd1;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
          y_n   <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_strobe.sv
// Directed testbench for decode_strobe with default parameters.
module tb_decode_strobe;

  logic       clk;
  logic       reset;
  logic       g1;
  logic       g2a_n;
  logic       g2b_n;
  logic [2:0] a;
  logic       req;
  logic [7:0] y_n;
  logic       busy;
  logic       done;
  logic       overrun;

  int total;
  int bad;

  decode_strobe #(
    .SEL_WIDTH(3),
    .PULSE_CYCLES(2),
    .GAP_CYCLES(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .g1(g1),
    .g2a_n(g2a_n),
    .g2b_n(g2b_n),
    .a(a),
    .req(req),
    .y_n(y_n),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    g1    = 1'b1;
    g2a_n = 1'b0;
    g2b_n = 1'b0;
    a     = 3'd0;
    req   = 1'b0;
    #12;
    chk("rst_y_n", 32'(y_n), 32'hFF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Single strobe on output 5.
    a = 3'd5; req = 1'b1;
    tick();
    req = 1'b0;
    chk("s5_e1_y", 32'(y_n), 32'hDF);
    chk("s5_e1_busy", 32'(busy), 32'h1);
    chk("s5_e1_done", 32'(done), 32'h0);
    tick();
    chk("s5_e2_y", 32'(y_n), 32'hDF);
    tick();
    chk("s5_e3_y", 32'(y_n), 32'hFF);
    chk("s5_e3_done", 32'(done), 32'h1);
    chk("s5_e3_busy", 32'(busy), 32'h1);
    tick();
    chk("s5_e4_busy", 32'(busy), 32'h0);
    chk("s5_e4_done", 32'(done), 32'h0);

    // Sweep every output once.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pat;
      pat = ~(8'd1 << i);
      a = 3'(i); req = 1'b1;
      tick();
      req = 1'b0;
      chk($sformatf("sw%0d_y1", i), 32'(y_n), 32'(pat));
      tick();
      chk($sformatf("sw%0d_y2", i), 32'(y_n), 32'(pat));
      tick();
      chk($sformatf("sw%0d_gap", i), 32'(y_n), 32'hFF);
      chk($sformatf("sw%0d_done", i), 32'(done), 32'h1);
      tick();
    end

    // Disabled request is discarded.
    g2b_n = 1'b1; a = 3'd4; req = 1'b1;
    tick();
    req = 1'b0;
    chk("dis_y", 32'(y_n), 32'hFF);
    chk("dis_busy", 32'(busy), 32'h0);
    chk("dis_ovr", 32'(overrun), 32'h0);
    g2b_n = 1'b0;
    tick();

    // Abort: g1 drops one clock into the strobe.
    a = 3'd3; req = 1'b1;
    tick();
    req = 1'b0;
    chk("ab_y1", 32'(y_n), 32'hF7);
    g1 = 1'b0;
    tick();
    chk("ab_y2", 32'(y_n), 32'hFF);
    chk("ab_done", 32'(done), 32'h0);
    chk("ab_busy", 32'(busy), 32'h1);
    tick();
    chk("ab_idle", 32'(busy), 32'h0);
    chk("ab_done2", 32'(done), 32'h0);
    g1 = 1'b1;
    tick();

    // Pending buffer and overrun.
    a = 3'd2; req = 1'b1;
    tick();
    chk("pq_y2", 32'(y_n), 32'hFB);
    a = 3'd6;
    tick();
    chk("pq_y2b", 32'(y_n), 32'hFB);
    a = 3'd1;
    tick();
    req = 1'b0;
    chk("pq_done", 32'(done), 32'h1);
    chk("pq_ovr", 32'(overrun), 32'h1);
    tick();
    chk("pq_idle_y", 32'(y_n), 32'hFF);
    tick();
    chk("pq_y6a", 32'(y_n), 32'hBF);
    tick();
    chk("pq_y6b", 32'(y_n), 32'hBF);
    tick();
    chk("pq_y6_end", 32'(y_n), 32'hFF);
    chk("pq_done6", 32'(done), 32'h1);
    tick();
    tick();
    chk("pq_no_y1", 32'(y_n), 32'hFF);
    chk("pq_busy", 32'(busy), 32'h0);
    chk("pq_ovr_sticky", 32'(overrun), 32'h1);

    // Asynchronous reset in the middle of a strobe.
    a = 3'd0; req = 1'b1;
    tick();
    req = 1'b0;
    chk("ar_y", 32'(y_n), 32'hFE);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_y_now", 32'(y_n), 32'hFF);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_ovr", 32'(overrun), 32'h0);
    chk("ar_done", 32'(done), 32'h0);
    tick();
    chk("ar_hold_y", 32'(y_n), 32'hFF);
    chk("ar_hold_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Operation resumes after reset release.
    a = 3'd7; req = 1'b1;
    tick();
    req = 1'b0;
    chk("post_y", 32'(y_n), 32'h7F);
    tick();
    tick();
    tick();
    chk("post_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
